// File: rtl/icache_2way_ctrl.sv
// icache_2way_ctrl: two-way set-associative read-only instruction cache with LRU block refill
module icache_2way_ctrl #(
  parameter int BLOCK_SIZE = 8,
  parameter int NUM_SETS   = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cpu_read,
  input  logic [31:0]             cpu_addr,
  input  logic                    flush,
  output logic [31:0]             cpu_rdata,
  output logic                    cpu_stall,
  output logic                    mem_read,
  output logic [31:0]             mem_addr,
  input  logic [BLOCK_SIZE*8-1:0] mem_rdata,
  input  logic                    mem_ready
);
  localparam int WPB = BLOCK_SIZE / 4;
  localparam int OB  = $clog2(BLOCK_SIZE);
  localparam int IB  = $clog2(NUM_SETS);
  localparam int TB  = 32 - OB - IB;
  localparam int WB  = (WPB > 1) ? $clog2(WPB) : 1;
  typedef enum logic {S_IDLE, S_FETCH} state_t;
  state_t                r_state, w_next;
  logic [NUM_SETS-1:0]   r_valid [2];
  logic [NUM_SETS-1:0]   r_lru;
  logic [TB-1:0]         r_tag [2][NUM_SETS];
  logic [31:0]           r_data [2][NUM_SETS][WPB];
  logic                  r_mem_read, r_victim;
  logic [31:0]           r_mem_addr;
  logic [IB-1:0]         w_idx, w_fidx;
  logic [TB-1:0]         w_tag, w_ftag;
  logic [WB-1:0]         w_word;
  logic                  w_hit0, w_hit1, w_hit, w_vic;
  logic [31:0]           w_word_data;
  assign w_idx       = cpu_addr[OB+IB-1:OB];
  assign w_tag       = cpu_addr[31:OB+IB];
  assign w_word      = WB'((cpu_addr >> 2) & 32'(WPB - 1));
  // Refill uses the registered block address so the line lands where the miss was taken.
  assign w_fidx      = r_mem_addr[OB+IB-1:OB];
  assign w_ftag      = r_mem_addr[31:OB+IB];
  assign w_hit0      = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
  assign w_hit1      = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
  assign w_hit       = w_hit0 | w_hit1;
  assign w_vic       = !r_valid[0][w_idx] ? 1'b0 : !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
  assign w_word_data = r_data[w_hit1][w_idx][w_word];
  assign mem_read    = r_mem_read;
  assign mem_addr    = r_mem_addr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end
  always_comb begin
    w_next    = r_state;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    if (r_state == S_FETCH) begin
      cpu_stall = 1'b1;
      w_next    = mem_ready ? S_IDLE : S_FETCH;
    end else if (flush) begin
      cpu_stall = 1'b1;
    end else if (cpu_read) begin
      cpu_stall = !w_hit;
      cpu_rdata = w_hit ? w_word_data : '0;
      w_next    = w_hit ? S_IDLE : S_FETCH;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid[0] <= '0;
      r_valid[1] <= '0;
      r_lru      <= '0;
      r_mem_read <= 1'b0;
      r_mem_addr <= '0;
      r_victim   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (flush) begin
        r_valid[0] <= '0;
        r_valid[1] <= '0;
        r_lru      <= '0;
      end else if (cpu_read && w_hit) begin
        r_lru[w_idx] <= ~w_hit1;
      end else if (cpu_read) begin
        r_victim   <= w_vic;
        r_mem_addr <= cpu_addr & ~32'(BLOCK_SIZE - 1);
        r_mem_read <= 1'b1;
      end
    end else if (mem_ready) begin
      r_valid[r_victim][w_fidx] <= 1'b1;
      r_lru[w_fidx]             <= ~r_victim;
      r_mem_read                <= 1'b0;
    end
  end
  // Tag and data arrays need no reset: a line is only ever read once its valid bit is set.
  always_ff @(posedge clk) begin
    if (r_state == S_FETCH && mem_ready) begin
      r_tag[r_victim][w_fidx] <= w_ftag;
      for (int w = 0; w < WPB; w++) r_data[r_victim][w_fidx][WB'(w)] <= mem_rdata[w*32 +: 32];
    end
  end
endmodule

// File: tb/tb_icache_2way_ctrl.sv
// tb_icache_2way_ctrl: directed and randomized checks of the 2-way icache against a block-level model
module tb_icache_2way_ctrl;
  localparam int BS  = 8;
  localparam int NS  = 8;
  localparam int WPB = BS / 4;
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_read = 1'b0;
  logic [31:0]       cpu_addr = '0;
  logic              flush = 1'b0;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              mem_read;
  logic [31:0]       mem_addr;
  logic [BS*8-1:0]   mem_rdata = '0;
  logic              mem_ready = 1'b0;
  int                n_tests = 0;
  int                n_fail = 0;
  logic [31:0]       mem_img [int unsigned];
  bit                m_valid [NS][2];
  int unsigned       m_blk [NS][2];
  bit                m_lru [NS];

  icache_2way_ctrl #(.BLOCK_SIZE(BS), .NUM_SETS(NS)) dut (
    .clk(clk), .reset(rst_n), .cpu_read(cpu_read), .cpu_addr(cpu_addr), .flush(flush),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] get_word(input int unsigned wa);
    return mem_img.exists(wa) ? mem_img[wa] : (wa * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic logic [BS*8-1:0] get_block(input int unsigned blk);
    logic [BS*8-1:0] b;
    for (int w = 0; w < WPB; w++) b[w*32 +: 32] = get_word(blk * WPB + w);
    return b;
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < NS; s++) begin
      m_valid[s][0] = 0;
      m_valid[s][1] = 0;
      m_lru[s] = 0;
    end
  endfunction

  // One fetch: hit answered in-cycle, or miss served by memory after lat extra cycles.
  task automatic do_read(input logic [31:0] a, input int lat);
    int unsigned blk = a / BS;
    int s = blk % NS;
    bit mh = 0, hw = 0, vic;
    int stalls;
    logic [31:0] exp_d = get_word(a / 4);
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_blk[s][w] == blk) begin mh = 1; hw = w[0]; end
    @(negedge clk);
    cpu_read = 1'b1; cpu_addr = a; mem_ready = 1'b0; flush = 1'b0;
    #1;
    n_tests++;
    if (cpu_stall !== !mh) begin n_fail++; $display("FAIL lookup a=%h stall=%b required %b", a, cpu_stall, !mh); end
    if (mh) begin
      n_tests++;
      if (cpu_rdata !== exp_d) begin n_fail++; $display("FAIL hit_data a=%h got %h required %h", a, cpu_rdata, exp_d); end
      n_tests++;
      if (mem_read !== 1'b0) begin n_fail++; $display("FAIL hit_mem_read a=%h got %b required 0", a, mem_read); end
      m_lru[s] = !hw;
    end else begin
      n_tests++;
      if (cpu_rdata !== 32'h0) begin n_fail++; $display("FAIL miss_rdata a=%h got %h required 0", a, cpu_rdata); end
      vic = !m_valid[s][0] ? 1'b0 : !m_valid[s][1] ? 1'b1 : m_lru[s];
      stalls = 1;
      for (int k = 0; k <= lat; k++) begin
        @(negedge clk);
        mem_ready = (k == lat);
        mem_rdata = get_block(blk);
        #1;
        stalls += int'(cpu_stall);
        n_tests++;
        if (mem_read !== 1'b1 || mem_addr !== blk * BS) begin
          n_fail++; $display("FAIL refill_req a=%h mem_read=%b mem_addr=%h required 1 %h", a, mem_read, mem_addr, blk * BS);
        end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = {$urandom, $urandom};
      #1;
      n_tests++;
      if (stalls !== lat + 2 || cpu_stall !== 1'b0) begin
        n_fail++; $display("FAIL miss_penalty a=%h stalled %0d then %b required %0d then 0", a, stalls, cpu_stall, lat + 2);
      end
      n_tests++;
      if (cpu_rdata !== exp_d || mem_read !== 1'b0) begin
        n_fail++; $display("FAIL refill_data a=%h got %h mem_read=%b required %h 0", a, cpu_rdata, mem_read, exp_d);
      end
      m_valid[s][vic] = 1;
      m_blk[s][vic] = blk;
      m_lru[s] = !vic;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_tests++;
    if (mem_read !== 1'b0 || mem_addr !== 32'h0 || cpu_stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_state mem_read=%b mem_addr=%h stall=%b rdata=%h required 0", mem_read, mem_addr, cpu_stall, cpu_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_cold_miss();
    do_read(32'h0000_0004, 3);
  endtask

  task automatic test_spatial_hit();
    do_read(32'h0000_0000, 3);
  endtask

  task automatic test_second_way();
    do_read(32'h0000_0040, 2);
    do_read(32'h0000_0000, 2);
    do_read(32'h0000_0040, 2);
  endtask

  task automatic test_lru_evict();
    do_read(32'h0000_0000, 1);
    do_read(32'h0000_0080, 1);
    do_read(32'h0000_0000, 1);
    do_read(32'h0000_0040, 1);
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush = 1'b1; cpu_read = 1'b1; cpu_addr = 32'h0;
    #1;
    n_tests++;
    if (cpu_stall !== 1'b1 || cpu_rdata !== 32'h0) begin
      n_fail++; $display("FAIL flush_stall stall=%b rdata=%h required 1 0", cpu_stall, cpu_rdata);
    end
    model_clear();
    do_read(32'h0000_0000, 2);
  endtask

  task automatic test_back_to_back();
    do_read(32'h0000_0008, 0);
    do_read(32'h0000_0010, 0);
    for (int i = 0; i < 6; i++) do_read(32'h0000_0000 + 32'((i % 3) * 8 + (i % 2) * 4), 0);
  endtask

  task automatic test_reset_mid_fetch();
    logic [31:0] a = 32'h0000_0100;
    @(negedge clk);
    cpu_read = 1'b1; cpu_addr = a;
    #1;
    n_tests++;
    if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_miss stall=%b required 1", cpu_stall); end
    @(negedge clk);
    #1;
    n_tests++;
    if (mem_read !== 1'b1) begin n_fail++; $display("FAIL rst_fetch_req mem_read=%b required 1", mem_read); end
    @(negedge clk);
    rst_n = 1'b0; cpu_read = 1'b0;
    #1;
    n_tests++;
    if (mem_read !== 1'b0 || mem_addr !== 32'h0 || cpu_stall !== 1'b0) begin
      n_fail++; $display("FAIL rst_abort mem_read=%b mem_addr=%h stall=%b required 0", mem_read, mem_addr, cpu_stall);
    end
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    model_clear();
    do_read(a, 2);
    do_read(32'h0000_0000, 1);
  endtask

  task automatic test_random();
    logic [31:0] tags [4] = '{32'h0, 32'h1, 32'h2, 32'h03FF_FFFF};
    logic [31:0] a;
    for (int i = 0; i < 300; i++) begin
      a = (tags[$urandom_range(3)] << 6) | 32'($urandom_range(NS - 1) * BS) | 32'($urandom_range(WPB - 1) * 4) | 32'($urandom_range(3));
      if ($urandom_range(19) == 0) begin
        @(negedge clk);
        flush = 1'b1; cpu_read = 1'b0;
        #1;
        n_tests++;
        if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL rand_flush stall=%b required 1", cpu_stall); end
        model_clear();
      end else if ($urandom_range(7) == 0) begin
        @(negedge clk);
        flush = 1'b0; cpu_read = 1'b0; mem_ready = $urandom_range(1) == 1;
        #1;
        n_tests++;
        if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0) begin
          n_fail++; $display("FAIL rand_idle stall=%b rdata=%h required 0 0", cpu_stall, cpu_rdata);
        end
      end else begin
        do_read(a, $urandom_range(4));
      end
    end
  endtask

  initial begin
    mem_img[0] = 32'h1111_1111;
    mem_img[1] = 32'h2222_2222;
    test_reset();
    test_cold_miss();
    test_spatial_hit();
    test_second_way();
    test_lru_evict();
    test_flush();
    test_back_to_back();
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/icache_2way_ctrl.md
# icache_2way_ctrl

Two-way set-associative, read-only instruction cache with block refill, placed between the RV32IM fetch stage and instruction memory inside the `RISCV_Processor` cache path. It answers fetches the same cycle on a hit and stalls fetch on a miss. During a miss it runs a refill state machine that loads one whole block from memory into the selected way, chosen by per-set LRU. The cache is invalidated as a whole by a flush request (e.g. `FENCE.I`).

## Interface

- `BLOCK_SIZE`, 8: bytes per block; power of two, ≥4; words per block `WPB = BLOCK_SIZE/4`.
- `NUM_SETS`, 8: sets; power of two, ≥2.
- Associativity is fixed at 2.

- `clk` input 1: the only clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `cpu_read` input 1: fetch request, held until not stalled.
- `cpu_addr` input 32: byte address; bits [1:0] ignored; held stable while `cpu_stall`=1.
- `flush` input 1: invalidate all lines.
- `cpu_rdata` output 32: fetched word.
- `cpu_stall` output 1: fetch must hold.
- `mem_read` output 1: block read request.
- `mem_addr` output 32: block-aligned address.
- `mem_rdata` input `BLOCK_SIZE*8`: refill block; word 0 in bits [31:0].
- `mem_ready` input 1: `mem_rdata` valid this cycle.

## Operation

- Address split: offset `OB=log2(BLOCK_SIZE)`, index `IB=log2(NUM_SETS)`.
  - Word select `cpu_addr[OB-1:2]`.
  - Index `cpu_addr[OB+IB-1:OB]`.
  - Tag is the remaining upper bits.
- Per set and way: valid bit, tag, data block. One LRU bit per set names the way to evict.
- Hit: `cpu_read`=1, and some way of the indexed set is valid with a matching tag. Both ways matching is impossible by construction.
- FSM states: IDLE, FETCH.
- IDLE:
  - `flush`=1 takes priority over a read.
    - At the edge, all valid bits are cleared and all LRU bits set to 0.
    - `cpu_stall`=1 in that cycle; the state remains IDLE.
  - Read hit:
    - `cpu_rdata` = the selected word (combinational); `cpu_stall`=0.
    - At the edge, LRU[set] is set to the opposite of the hit way.
  - Read miss:
    - `cpu_stall`=1 (combinational); `cpu_rdata`=0.
    - Victim way: way 0 if invalid, else way 1 if invalid, else LRU[set].
    - At the edge, register the victim, the block address `{tag,index,OB zeros}` into `mem_addr`, and `mem_read`=1; go to FETCH.
  - No read: `cpu_stall`=0, `cpu_rdata`=0.
- FETCH:
  - `mem_read`=1 and `mem_addr` are held; `cpu_stall`=1; `cpu_rdata`=0; `flush` is ignored.
  - On `mem_ready`=1, at the edge:
    - Write `mem_rdata` into the victim way and set its tag and valid.
    - Set LRU[set] to the opposite of the victim.
    - Clear `mem_read` (registered); go to IDLE.
  - The next cycle re-looks up in IDLE, hits, and releases the stall.
- `mem_ready` is ignored outside FETCH.
- Reset, asynchronous:
  - State IDLE.
  - All valid and LRU bits 0.
  - `mem_read`=0, `mem_addr`=0; victim register 0.
  - Outputs: `cpu_stall`=0 (with `cpu_read`=0), `cpu_rdata`=0.
  - Reset during FETCH abandons the refill; no line is written.

## Timing

- Hit latency: 0 cycles (same-cycle data).
- Miss:
  - Cycle T0: lookup misses, stall asserted.
  - Cycles T0+1 … Tr: `mem_read`=1.
  - At Tr, `mem_ready`=1 and the line is written at the Tr edge.
  - Cycle Tr+1: hit, stall=0.
  - Total penalty with memory latency L (`mem_ready` L cycles after `mem_read` rises): L+2 stalled cycles.
- `mem_read` and `mem_addr` are registered outputs. `cpu_stall` and `cpu_rdata` are combinational from state plus lookup.
- Back-to-back hits to any sets proceed one per cycle with no bubble.

## Test plan

- Cold miss, memory latency 3:
  - Stimulus: after reset, read 0x0000_0004; memory returns block {0x22222222, 0x11111111}.
  - Required: stall for 5 cycles, `mem_addr`=0x0000_0000, then `cpu_rdata`=0x22222222 with stall=0.
- Spatial hit:
  - Stimulus: read 0x0000_0000 next cycle.
  - Required: `cpu_rdata`=0x11111111, no stall, `mem_read` stays 0.
- Second way fill:
  - Stimulus: read 0x0000_0040 (same set 0, different tag).
  - Required: miss, fills way 1; then 0x0 and 0x40 both hit.
- LRU eviction:
  - Stimulus: hit 0x0, then read 0x0000_0080.
  - Required: way 1 (0x40) is evicted; 0x0 still hits and 0x40 misses.
- Flush:
  - Stimulus: assert `flush` in IDLE for 1 cycle.
  - Required: stall=1 that cycle; the subsequent read of 0x0 misses with `mem_addr`=0x0.
- Reset mid-FETCH:
  - Stimulus: drop `reset` while `mem_read`=1.
  - Required: `mem_read`=0 immediately; after release, read of the same address misses again; `mem_ready` pulses in IDLE cause no write.
